usb_buffer_ctrl: RTL and testbench
==================================

# usb_buffer_ctrl

Controller for the shared USB endpoint data buffer that sits between `usb_rx`, the USB TX encoder and the AHB slave. It owns a DEPTH-byte FIFO and its pointers and occupancy count. It grants buffer ownership to exactly one direction at a time: an RX data packet being captured, or TX data being loaded by AHB and drained by TX. It also flags packet completion and access errors to the AHB side.

## Interface
- DEPTH, 64, buffer size in bytes; power of two, 4..256; PW = log2(DEPTH)
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- rx_packet  in  3  decoded PID from usb_rx: 000 none, 001 OUT, 010 IN, 011 DATA, 100 ACK, 101 NAK, 110 STALL, 111 error
- store_rx_packet  in  1  one-cycle strobe, rx_packet_data valid
- rx_packet_data  in  8  received byte
- rx_eop  in  1  one-cycle pulse, current RX packet ended
- rx_error  in  1  one-cycle pulse, RX CRC/stuff/PID error on current packet
- store_tx_data  in  1  AHB push strobe
- tx_data_in  in  8  AHB push byte
- get_rx_data  in  1  AHB pop strobe (RX data)
- rx_data_out  out  8  head byte for AHB; 8'h00 when empty
- get_tx_packet_data  in  1  TX encoder pop strobe
- tx_packet_data  out  8  head byte for TX; 8'h00 when empty
- clear  in  1  synchronous flush
- buffer_occupancy  out  PW+1  bytes held
- rx_data_ready  out  1  complete RX data packet held
- buffer_error  out  1  sticky access error

## Operation
- States: IDLE, RX_FILL, RX_HOLD, TX_LOAD. Reset state is IDLE with pointers and count at 0.
- IDLE:
  - store_rx_packet with rx_packet==011 writes the byte and moves to RX_FILL.
  - store_rx_packet with any other rx_packet is ignored; token and handshake PIDs are not buffered.
  - store_tx_data writes the byte and moves to TX_LOAD.
  - If store_rx_packet (with rx_packet==011) and store_tx_data arrive in the same cycle, RX wins. The AHB push is dropped and buffer_error is set.
- RX_FILL:
  - Every store_rx_packet writes one byte, regardless of rx_packet.
  - rx_eop moves to RX_HOLD if the count after this cycle is >0, otherwise to IDLE.
  - A byte strobed in the same cycle as rx_eop is written first.
  - rx_error handling depends on configuration.
- RX_HOLD:
  - get_rx_data pops one byte. When the count reaches 0, the state moves to IDLE.
  - store_rx_packet is dropped and sets buffer_error; the host must not send DATA before the buffer is drained.
- TX_LOAD:
  - store_tx_data pushes; get_tx_packet_data pops. A push and a pop in the same cycle leave the count unchanged.
  - A pop that brings the count to 0 returns to IDLE, unless a push occurs in the same cycle.
  - store_rx_packet is dropped and sets buffer_error.
- Errors (each sets buffer_error; the offending access has no effect):
  - push when count==DEPTH
  - pop when count==0
  - get_rx_data outside RX_HOLD
  - get_tx_packet_data outside TX_LOAD
- A valid access in the same cycle as an erroring one still takes effect.
- clear has the highest priority. It zeroes the pointers and count, goes to IDLE, clears buffer_error, and ignores all strobes that cycle.
- Pointers are PW bits and wrap modulo DEPTH. The count is PW+1 bits, range 0..DEPTH.

## Timing
- Reset values:
  - buffer_occupancy=0, rx_data_ready=0, buffer_error=0
  - rx_data_out=8'h00, tx_packet_data=8'h00
  - buffer contents are undefined
- Strobes are sampled on the rising clk edge. buffer_occupancy, rx_data_ready and buffer_error are registered and update one cycle after the causing strobe.
- rx_data_out and tx_packet_data are first-word-fall-through, combinational from mem[rptr], and gated to 0 when the count is 0. A pop advances the head on the next edge.
- Write-to-read latency: a byte is visible at the head one cycle after its push edge.
- rx_data_ready equals (state==RX_HOLD) and rises one cycle after rx_eop.
- Reset asserted mid-packet returns to IDLE immediately and asynchronously; any partial packet is discarded.

## Configuration
- USB_BUF_RX_ERR_FLUSH_EN defined: rx_error in RX_FILL flushes the buffer (count 0) and goes to IDLE next cycle. rx_data_ready never rises for that packet. buffer_error is not set.
- USB_BUF_RX_ERR_FLUSH_EN undefined: rx_error is ignored, and the packet completes normally on rx_eop.

## Test plan
- Reset, DATA PID + bytes 8'hD3, 8'hF0, then rx_eop -> occupancy 2, rx_data_ready=1. Two get_rx_data pops return D3 then F0; then occupancy 0, state IDLE, rx_data_ready=0.
- IN token (rx_packet=010) with store_rx_packet -> occupancy stays 0, rx_data_ready 0, buffer_error 0.
- AHB pushes 8'h11, 8'h22, 8'h33 with simultaneous push+pop on the third -> tx_packet_data sequence 11, 22, 33; final pop returns IDLE with occupancy 0.
- Write DEPTH RX bytes plus one extra -> occupancy=DEPTH, buffer_error=1, extra byte lost. clear -> occupancy 0, buffer_error 0.
- In RX_HOLD, a new DATA store_rx_packet -> dropped, buffer_error=1, held bytes intact. get_tx_packet_data in RX_HOLD -> error, no pop.
- RX bytes 8'hAA, 8'hBB then rx_error then rx_eop:
  - with USB_BUF_RX_ERR_FLUSH_EN -> occupancy 0, IDLE, rx_data_ready 0
  - without it -> occupancy 2, rx_data_ready 1

Source files
------------

// File: rtl/usb_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// usb_buffer_ctrl
// Owns the shared USB endpoint byte FIFO and decides which direction may use
// it. Only one direction owns the buffer at a time: an RX DATA packet being
// captured and then drained by AHB, or TX data loaded by AHB and drained by
// the TX encoder. It also reports packet completion and access errors.
//
// Optional build macro: USB_BUF_RX_ERR_FLUSH_EN
//   defined   : rx_error_i during RX capture discards the packet
//   undefined : rx_error_i is ignored, the packet completes on rx_eop_i
//
// Ports
//   clk_i                 system clock, rising edge
//   n_rst_i               asynchronous active-low reset
//   rx_packet_i[2:0]      decoded PID from usb_rx (011 = DATA)
//   store_rx_packet_i     strobe, rx_packet_data_i valid
//   rx_packet_data_i[7:0] received byte
//   rx_eop_i              current RX packet ended
//   rx_error_i            current RX packet has an error
//   store_tx_data_i       AHB push strobe
//   tx_data_in_i[7:0]     AHB push byte
//   get_rx_data_i         AHB pop strobe
//   rx_data_out_o[7:0]    head byte for AHB, 8'h00 when empty
//   get_tx_packet_data_i  TX encoder pop strobe
//   tx_packet_data_o[7:0] head byte for TX, 8'h00 when empty
//   clear_i               synchronous flush, highest priority
//   buffer_occupancy_o    bytes held (PW+1 bits)
//   rx_data_ready_o       a complete RX DATA packet is held
//   buffer_error_o        sticky access error
// ---------------------------------------------------------------------------
module usb_buffer_ctrl #(
  parameter int DEPTH = 64,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          n_rst_i,
  input  logic [2:0]    rx_packet_i,
  input  logic          store_rx_packet_i,
  input  logic [7:0]    rx_packet_data_i,
  input  logic          rx_eop_i,
  input  logic          rx_error_i,
  input  logic          store_tx_data_i,
  input  logic [7:0]    tx_data_in_i,
  input  logic          get_rx_data_i,
  output logic [7:0]    rx_data_out_o,
  input  logic          get_tx_packet_data_i,
  output logic [7:0]    tx_packet_data_o,
  input  logic          clear_i,
  output logic [PW:0]   buffer_occupancy_o,
  output logic          rx_data_ready_o,
  output logic          buffer_error_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RX_FILL = 2'd1;
  localparam logic [1:0] RX_HOLD = 2'd2;
  localparam logic [1:0] TX_LOAD = 2'd3;

  localparam logic [2:0]  PID_DATA = 3'b011;
  localparam logic [PW:0] FULL_C   = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_C    = (PW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          err_set_s;
  logic          flush_s;
  logic [7:0]    wdata_s;
  logic          full_s;
  logic          empty_s;
  logic [7:0]    head_s;

  assign full_s  = (count_q == FULL_C);
  assign empty_s = (count_q == {(PW+1){1'b0}});

  // Ownership FSM, access arbitration and error detection.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    flush_s   = 1'b0;
    wdata_s   = 8'h00;

    case (state_q)
      IDLE: begin
        if (store_rx_packet_i && (rx_packet_i == PID_DATA)) begin
          // RX wins a tie with an AHB push; the push is reported as an error.
          wdata_s   = rx_packet_data_i;
          push_s    = !full_s;
          err_set_s = full_s | store_tx_data_i;
          state_d   = RX_FILL;
        end else if (store_tx_data_i) begin
          wdata_s   = tx_data_in_i;
          push_s    = !full_s;
          err_set_s = full_s;
          state_d   = TX_LOAD;
        end else begin
          state_d = IDLE;
        end
        if (get_rx_data_i || get_tx_packet_data_i) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = err_set_s;
        end
      end

      RX_FILL: begin
        // Any byte strobed while capturing belongs to the packet.
        wdata_s   = rx_packet_data_i;
        push_s    = store_rx_packet_i && !full_s;
        err_set_s = (store_rx_packet_i && full_s) | store_tx_data_i |
                    get_rx_data_i | get_tx_packet_data_i;
        if (rx_eop_i) begin
          state_d = (!empty_s || push_s) ? RX_HOLD : IDLE;
        end else begin
          state_d = RX_FILL;
        end
`ifdef USB_BUF_RX_ERR_FLUSH_EN
        if (rx_error_i) begin
          flush_s = 1'b1;
          state_d = IDLE;
        end else begin
          flush_s = 1'b0;
        end
`endif
      end

      RX_HOLD: begin
        pop_s     = get_rx_data_i && !empty_s;
        err_set_s = (get_rx_data_i && empty_s) | store_rx_packet_i |
                    store_tx_data_i | get_tx_packet_data_i;
        if (pop_s && (count_q == ONE_C)) begin
          state_d = IDLE;
        end else begin
          state_d = RX_HOLD;
        end
      end

      TX_LOAD: begin
        wdata_s   = tx_data_in_i;
        push_s    = store_tx_data_i && !full_s;
        pop_s     = get_tx_packet_data_i && !empty_s;
        err_set_s = (store_tx_data_i && full_s) |
                    (get_tx_packet_data_i && empty_s) |
                    store_rx_packet_i | get_rx_data_i;
        // Draining the last byte releases the buffer unless refilled now.
        if (pop_s && !push_s && (count_q == ONE_C)) begin
          state_d = IDLE;
        end else begin
          state_d = TX_LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    wptr_d = push_s ? (wptr_q + {{(PW-1){1'b0}}, 1'b1}) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + {{(PW-1){1'b0}}, 1'b1}) : rptr_q;

    if (flush_s) begin
      wptr_d  = {PW{1'b0}};
      rptr_d  = {PW{1'b0}};
      count_d = {(PW+1){1'b0}};
    end else begin
      count_d = count_d;
    end

    err_d = err_q | err_set_s;

    // Flush overrides everything, including any write this cycle.
    if (clear_i) begin
      state_d = IDLE;
      wptr_d  = {PW{1'b0}};
      rptr_d  = {PW{1'b0}};
      count_d = {(PW+1){1'b0}};
      err_d   = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
    end else begin
      err_d = err_d;
    end
  end

  // Control state, pointers, occupancy and sticky error.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {(PW+1){1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wptr_q] <= wdata_s;
    end
  end

  // First-word-fall-through head, forced to zero when nothing is held.
  always_comb begin
    if (empty_s) begin
      head_s = 8'h00;
    end else begin
      head_s = mem_q[rptr_q];
    end
  end

  assign rx_data_out_o      = head_s;
  assign tx_packet_data_o   = head_s;
  assign buffer_occupancy_o = count_q;
  assign rx_data_ready_o    = (state_q == RX_HOLD);
  assign buffer_error_o     = err_q;

endmodule

// File: tb/tb_usb_buffer_ctrl.sv
module tb_usb_buffer_ctrl;

  localparam int DEPTH = 64;
  localparam int PW    = 6;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [2:0]    rx_packet = 3'b000;
  logic          store_rx_packet = 1'b0;
  logic [7:0]    rx_packet_data = 8'h00;
  logic          rx_eop = 1'b0;
  logic          rx_error = 1'b0;
  logic          store_tx_data = 1'b0;
  logic [7:0]    tx_data_in = 8'h00;
  logic          get_rx_data = 1'b0;
  logic [7:0]    rx_data_out;
  logic          get_tx_packet_data = 1'b0;
  logic [7:0]    tx_packet_data;
  logic          clear = 1'b0;
  logic [PW:0]   buffer_occupancy;
  logic          rx_data_ready;
  logic          buffer_error;

  int checks = 0;
  int failures = 0;

  usb_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i                (clk),
    .n_rst_i              (n_rst),
    .rx_packet_i          (rx_packet),
    .store_rx_packet_i    (store_rx_packet),
    .rx_packet_data_i     (rx_packet_data),
    .rx_eop_i             (rx_eop),
    .rx_error_i           (rx_error),
    .store_tx_data_i      (store_tx_data),
    .tx_data_in_i         (tx_data_in),
    .get_rx_data_i        (get_rx_data),
    .rx_data_out_o        (rx_data_out),
    .get_tx_packet_data_i (get_tx_packet_data),
    .tx_packet_data_o     (tx_packet_data),
    .clear_i              (clear),
    .buffer_occupancy_o   (buffer_occupancy),
    .rx_data_ready_o      (rx_data_ready),
    .buffer_error_o       (buffer_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Apply currently driven strobes for one edge, then drop them.
  task automatic step();
    @(posedge clk);
    #1;
    store_rx_packet    = 1'b0;
    rx_eop             = 1'b0;
    rx_error           = 1'b0;
    store_tx_data      = 1'b0;
    get_rx_data        = 1'b0;
    get_tx_packet_data = 1'b0;
    clear              = 1'b0;
  endtask

  task automatic rx_byte(input logic [2:0] pid, input logic [7:0] b);
    rx_packet       = pid;
    rx_packet_data  = b;
    store_rx_packet = 1'b1;
    step();
  endtask

  initial begin
    #12;
    chk("rst_occ", int'(buffer_occupancy), 0);
    chk("rst_rdy", int'(rx_data_ready), 0);
    chk("rst_err", int'(buffer_error), 0);
    chk("rst_rxout", int'(rx_data_out), 0);
    chk("rst_txout", int'(tx_packet_data), 0);
    n_rst = 1'b1;
    step();

    // RX DATA packet D3,F0 then drained by AHB
    rx_byte(3'b011, 8'hD3);
    chk("rx1_occ", int'(buffer_occupancy), 1);
    chk("rx1_head", int'(rx_data_out), 'hD3);
    chk("rx1_rdy", int'(rx_data_ready), 0);
    rx_byte(3'b011, 8'hF0);
    rx_eop = 1'b1; step();
    chk("rx_eop_occ", int'(buffer_occupancy), 2);
    chk("rx_eop_rdy", int'(rx_data_ready), 1);
    chk("rx_pop1_data", int'(rx_data_out), 'hD3);
    get_rx_data = 1'b1; step();
    chk("rx_pop2_data", int'(rx_data_out), 'hF0);
    chk("rx_pop1_occ", int'(buffer_occupancy), 1);
    get_rx_data = 1'b1; step();
    chk("rx_done_occ", int'(buffer_occupancy), 0);
    chk("rx_done_rdy", int'(rx_data_ready), 0);
    chk("rx_done_out", int'(rx_data_out), 0);
    chk("rx_done_err", int'(buffer_error), 0);

    // IN token is not buffered
    rx_byte(3'b010, 8'h5C);
    chk("tok_occ", int'(buffer_occupancy), 0);
    chk("tok_rdy", int'(rx_data_ready), 0);
    chk("tok_err", int'(buffer_error), 0);

    // TX load/drain with a simultaneous push+pop
    store_tx_data = 1'b1; tx_data_in = 8'h11; step();
    chk("tx1_occ", int'(buffer_occupancy), 1);
    chk("tx1_head", int'(tx_packet_data), 'h11);
    store_tx_data = 1'b1; tx_data_in = 8'h22; step();
    chk("tx2_occ", int'(buffer_occupancy), 2);
    store_tx_data = 1'b1; tx_data_in = 8'h33; get_tx_packet_data = 1'b1; step();
    chk("tx3_occ", int'(buffer_occupancy), 2);
    chk("tx3_head", int'(tx_packet_data), 'h22);
    get_tx_packet_data = 1'b1; step();
    chk("tx4_head", int'(tx_packet_data), 'h33);
    chk("tx4_occ", int'(buffer_occupancy), 1);
    get_tx_packet_data = 1'b1; step();
    chk("tx5_occ", int'(buffer_occupancy), 0);
    chk("tx5_head", int'(tx_packet_data), 0);
    chk("tx5_err", int'(buffer_error), 0);
    // Back in IDLE: a TX pop is now an error
    get_tx_packet_data = 1'b1; step();
    chk("idle_txpop_err", int'(buffer_error), 1);
    chk("idle_txpop_occ", int'(buffer_occupancy), 0);
    clear = 1'b1; step();
    chk("clr1_err", int'(buffer_error), 0);

    // Fill to DEPTH plus one extra byte
    for (int i = 0; i < DEPTH; i++) rx_byte(3'b011, 8'(8'h40 + i));
    chk("full_occ", int'(buffer_occupancy), DEPTH);
    chk("full_err0", int'(buffer_error), 0);
    rx_byte(3'b011, 8'hFF);
    chk("ovf_occ", int'(buffer_occupancy), DEPTH);
    chk("ovf_err", int'(buffer_error), 1);
    rx_eop = 1'b1; step();
    chk("ovf_rdy", int'(rx_data_ready), 1);
    chk("ovf_head", int'(rx_data_out), 'h40);
    // clear wins over a simultaneous store
    clear = 1'b1; rx_packet = 3'b011; store_rx_packet = 1'b1; step();
    chk("clr2_occ", int'(buffer_occupancy), 0);
    chk("clr2_err", int'(buffer_error), 0);
    chk("clr2_rdy", int'(rx_data_ready), 0);

    // RX_HOLD: new DATA is dropped
    rx_byte(3'b011, 8'h5A);
    rx_byte(3'b011, 8'hA5);
    rx_eop = 1'b1; step();
    rx_byte(3'b011, 8'h77);
    chk("hold_drop_err", int'(buffer_error), 1);
    chk("hold_drop_occ", int'(buffer_occupancy), 2);
    chk("hold_drop_head", int'(rx_data_out), 'h5A);
    clear = 1'b1; step();
    // RX_HOLD: TX pop is an error and pops nothing
    rx_byte(3'b011, 8'h5A);
    rx_byte(3'b011, 8'hA5);
    rx_eop = 1'b1; step();
    get_tx_packet_data = 1'b1; step();
    chk("hold_txpop_err", int'(buffer_error), 1);
    chk("hold_txpop_occ", int'(buffer_occupancy), 2);
    chk("hold_txpop_head", int'(rx_data_out), 'h5A);
    clear = 1'b1; step();

    // rx_error during capture
    rx_byte(3'b011, 8'hAA);
    rx_byte(3'b011, 8'hBB);
    rx_error = 1'b1; step();
    rx_eop = 1'b1; step();
`ifdef USB_BUF_RX_ERR_FLUSH_EN
    chk("rxerr_occ", int'(buffer_occupancy), 0);
    chk("rxerr_rdy", int'(rx_data_ready), 0);
    chk("rxerr_head", int'(rx_data_out), 0);
`else
    chk("rxerr_occ", int'(buffer_occupancy), 2);
    chk("rxerr_rdy", int'(rx_data_ready), 1);
    chk("rxerr_head", int'(rx_data_out), 'hAA);
`endif
    chk("rxerr_err", int'(buffer_error), 0);

    // Asynchronous reset mid-packet
    clear = 1'b1; step();
    rx_byte(3'b011, 8'h01);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_occ", int'(buffer_occupancy), 0);
    chk("arst_rdy", int'(rx_data_ready), 0);
    #10 n_rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
